// File: rtl/aes_pkg.sv
// Shared widths and the assembly-path state encoding for the AES block packer.
package aes_pkg;

    localparam int AES_WORD_W    = 32;
    localparam int AES_BLK_W     = 128;
    localparam int AES_BLK_WORDS = 4;

    typedef enum logic {
        FILL = 1'b0,
        HELD = 1'b1
    } pack_state_e;

endpackage

// File: rtl/aes_block_packer_if.sv
// Key, plaintext-word and packed-block handshake bundle between the packer and its neighbours.
interface aes_block_packer_if
    import aes_pkg::*;
#(
    parameter int N = 128
);

    logic                  key_wr;
    logic [AES_WORD_W-1:0] key_word;
    logic                  key_loaded;
    logic                  din_valid;
    logic [AES_WORD_W-1:0] din_word;
    logic                  din_ready;
    logic                  flush;
    logic                  blk_valid;
    logic                  blk_ready;
    logic [AES_BLK_W-1:0]  blk_data;
    logic [N-1:0]          blk_key;

    modport master (
        output key_wr, key_word, din_valid, din_word, flush, blk_ready,
        input  key_loaded, din_ready, blk_valid, blk_data, blk_key
    );

    modport slave (
        input  key_wr, key_word, din_valid, din_word, flush, blk_ready,
        output key_loaded, din_ready, blk_valid, blk_data, blk_key
    );

endinterface

// File: rtl/aes_key_loader.sv
// Key shift register, most-significant word first; key_loaded rises after the nk-th word.
module aes_key_loader
    import aes_pkg::*;
#(
    parameter int N  = 128,
    parameter int nk = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_wr,
    input  logic [AES_WORD_W-1:0] key_word,
    output logic [N-1:0]          key,
    output logic                  key_loaded
);

    localparam int CW = $clog2(nk + 1);

    logic [N-1:0]  key_q, key_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_base;
    logic          loaded_q, loaded_d;

    always_comb begin
        key_d    = key_q;
        cnt_d    = cnt_q;
        loaded_d = loaded_q;
        // A write on a complete key starts a fresh one with this word as word 0.
        cnt_base = loaded_q ? '0 : cnt_q;
        if (key_wr) begin
            key_d = {key_q[N-AES_WORD_W-1:0], key_word};
            if (cnt_base == CW'(nk - 1)) begin
                cnt_d    = '0;
                loaded_d = 1'b1;
            end else begin
                cnt_d    = cnt_base + 1'b1;
                loaded_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q    <= '0;
            cnt_q    <= '0;
            loaded_q <= 1'b0;
        end else begin
            key_q    <= key_d;
            cnt_q    <= cnt_d;
            loaded_q <= loaded_d;
        end
    end

    assign key        = key_q;
    assign key_loaded = loaded_q;

endmodule

// File: rtl/aes_block_packer.sv
// Packs four 32-bit plaintext words into a 128-bit block and binds it to the current cipher key.
// state | meaning
// FILL  | collecting words 0..3 into the assembly buffer
// HELD  | complete block waiting for the output register to free up
module aes_block_packer
    import aes_pkg::*;
#(
    parameter int N  = 128,
    parameter int nk = 4
) (
    input logic              clk,
    input logic              rst_n,
    aes_block_packer_if.slave bus
);

    logic [N-1:0]         key_cur;
    logic                 key_loaded;
    pack_state_e          state_q, state_d;
    logic [1:0]           wcnt_q, wcnt_d;
    logic [AES_BLK_W-1:0] asm_q, asm_d;
    logic [N-1:0]         held_key_q, held_key_d;
    logic                 out_valid_q, out_valid_d;
    logic [AES_BLK_W-1:0] out_data_q, out_data_d;
    logic [N-1:0]         out_key_q, out_key_d;
    logic                 din_ready, word_fire, out_free;

    aes_key_loader #(.N(N), .nk(nk)) u_key_loader (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_wr     (bus.key_wr),
        .key_word   (bus.key_word),
        .key        (key_cur),
        .key_loaded (key_loaded)
    );

    assign din_ready = key_loaded && (state_q == FILL) && !bus.flush;
    assign word_fire = bus.din_valid && din_ready;
    assign out_free  = !out_valid_q || bus.blk_ready;

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        asm_d       = asm_q;
        held_key_d  = held_key_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_key_d   = out_key_q;
        if (out_valid_q && bus.blk_ready) out_valid_d = 1'b0;

        if (bus.flush) begin
            state_d = FILL;
            wcnt_d  = '0;
        end else if (state_q == HELD) begin
            if (out_free) begin
                out_valid_d = 1'b1;
                out_data_d  = asm_q;
                out_key_d   = held_key_q;
                state_d     = FILL;
                wcnt_d      = '0;
            end
        end else if (word_fire) begin
            for (int i = 0; i < AES_BLK_WORDS; i++) begin
                if (wcnt_q == 2'(i)) asm_d[AES_BLK_W-1-AES_WORD_W*i -: AES_WORD_W] = bus.din_word;
            end
            wcnt_d = wcnt_q + 2'd1;
            if (wcnt_q == 2'(AES_BLK_WORDS - 1)) begin
                // A block parked in HELD keeps the key it completed under.
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = asm_d;
                    out_key_d   = key_cur;
                end else begin
                    state_d    = HELD;
                    held_key_d = key_cur;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            wcnt_q      <= '0;
            asm_q       <= '0;
            held_key_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_key_q   <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            asm_q       <= asm_d;
            held_key_q  <= held_key_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_key_q   <= out_key_d;
        end
    end

    assign bus.din_ready  = din_ready;
    assign bus.key_loaded = key_loaded;
    assign bus.blk_valid  = out_valid_q;
    assign bus.blk_data   = out_data_q;
    assign bus.blk_key    = out_key_q;

endmodule
